// File: rtl/dense_mem_pkg.sv
// Shared definitions for the dense-layer weight memory stream.
//   - default parameter values
//   - row-pair sequencer states
//   - tag carried alongside each bank read
//   - out_data word-index helper
package dense_mem_pkg;

  localparam int DEF_NUM_BANKS = 16;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_DEPTH     = 256;
  localparam int DEF_RD_LAT    = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Travels through the read-latency pipeline next to the bank data.
  typedef struct packed {
    logic valid;
    logic last;
    logic pad_a;   // force port-A words to zero
    logic pad_b;   // force port-B words to zero
  } rd_tag_t;

  // Word 2b carries bank b row a; word 2b+1 carries bank b row a+1.
  function automatic int word_idx(input int bank, input logic port_b);
    return 2 * bank + (port_b ? 1 : 0);
  endfunction

endpackage

// File: rtl/dense_wmem_bank.sv
// One weight bank: read-first dual-read-port array with a write port.
// Read data appears RD_LAT cycles after the address is presented.
// Ports:
//   clk          clock
//   wr_en_i      write enable for this bank
//   wr_addr_i    write row
//   wr_data_i    write word
//   rd_addr_a_i  port A read row
//   rd_addr_b_i  port B read row
//   rd_data_a_o  port A read word (RD_LAT cycles later)
//   rd_data_b_o  port B read word (RD_LAT cycles later)
module dense_wmem_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic [DATA_W-1:0] rd_data_a_o,
  output logic [DATA_W-1:0] rd_data_b_o
);

  logic [DATA_W-1:0] mem_q    [DEPTH];
  logic [DATA_W-1:0] pipe_a_q [RD_LAT];
  logic [DATA_W-1:0] pipe_b_q [RD_LAT];

  // NOTE: storage arrays carry no reset; validity is tracked by separate
  // resettable flags, so clearing the data itself would only cost logic.
  // NOTE: with non-blocking assignments the read samples mem_q before the
  // same-edge write lands, which gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    pipe_a_q[0] <= mem_q[rd_addr_a_i];
    pipe_b_q[0] <= mem_q[rd_addr_b_i];
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_a_q[i] <= pipe_a_q[i-1];
      pipe_b_q[i] <= pipe_b_q[i-1];
    end
  end

  assign rd_data_a_o = pipe_a_q[RD_LAT-1];
  assign rd_data_b_o = pipe_b_q[RD_LAT-1];

endmodule

// File: rtl/dense_wmem_stream.sv
// Dense-layer weight memory streamer. Streams row pairs (a, a+1) from every
// bank per beat into an output FIFO with ready/valid backpressure; issue is
// credit-limited so the FIFO can never overflow.
// Optional feature macro: DENSE_WMEM_ZERO_PAD_EN -- when defined, any read
// row that wrapped past DEPTH-1 within the burst returns zero words.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        start pulse (accepted only in IDLE)
//   base_addr    first row of the burst
//   num_pairs    row pairs to stream (0 gives an immediate done)
//   busy         burst in progress
//   done         one-cycle pulse once the last pair has been popped
//   out_valid / out_ready / out_data / out_last   output stream
//   wr_en, wr_bank, wr_addr, wr_data               runtime weight write
module dense_wmem_stream
  import dense_mem_pkg::*;
#(
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int RD_LAT    = DEF_RD_LAT,
  parameter int FIFO_D    = RD_LAT + 2,
  parameter int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [ADDR_W-1:0]             num_pairs,
  output logic                          busy,
  output logic                          done,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*NUM_BANKS*DATA_W-1:0] out_data,
  output logic                          out_last,
  input  logic                          wr_en,
  input  logic [BANK_W-1:0]             wr_bank,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data
);

  localparam int OUT_W = 2 * NUM_BANKS * DATA_W;
  localparam int CNT_W = $clog2(FIFO_D + 1);
  localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, rem_q, rem_d, addr_b;
  logic              issue, credit, push, pop, pad_a, pad_b;
  logic [CNT_W-1:0]  in_flight, fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W:0]    occupancy;
  rd_tag_t           tag_q [RD_LAT];
  rd_tag_t           tag_in, tag_out;
  logic [DATA_W-1:0] rd_a [NUM_BANKS];
  logic [DATA_W-1:0] rd_b [NUM_BANKS];
  logic [OUT_W-1:0]  push_data;
  logic [OUT_W-1:0]  fifo_data_q [FIFO_D];
  logic              fifo_last_q [FIFO_D];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------- bank array ----------------
  assign addr_b = ptr_q + ADDR_W'(1);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic bank_we;
    assign bank_we = wr_en && (wr_bank == BANK_W'(b));
    dense_wmem_bank #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
    ) u_bank (
      .clk        (clk),
      .wr_en_i    (bank_we),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .rd_addr_a_i(ptr_q),
      .rd_addr_b_i(addr_b),
      .rd_data_a_o(rd_a[b]),
      .rd_data_b_o(rd_b[b])
    );
  end

  // ---------------- credit and issue ----------------
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + CNT_W'(tag_q[i].valid);
  end

  assign occupancy = {1'b0, in_flight} + {1'b0, fifo_cnt_q};
  assign credit    = occupancy < (CNT_W+1)'(FIFO_D);
  assign issue     = (state_q == ISSUE) && credit;

`ifdef DENSE_WMEM_ZERO_PAD_EN
  // Sticky flag: the pointer has wrapped at least once during this burst.
  logic              wrapped_q, wrapped_d;
  logic [ADDR_W:0]   ptr_plus2;

  always_comb begin
    ptr_plus2 = {1'b0, ptr_q} + (ADDR_W+1)'(2);
    pad_a     = wrapped_q;
    pad_b     = wrapped_q || (ptr_q == '1);  // ptr+1 wraps on its own
    wrapped_d = wrapped_q;
    if (state_q == IDLE) wrapped_d = 1'b0;
    else if (issue)      wrapped_d = wrapped_q || ptr_plus2[ADDR_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrapped_q <= 1'b0;
    else        wrapped_q <= wrapped_d;
  end
`else
  assign pad_a = 1'b0;
  assign pad_b = 1'b0;
`endif

  // ---------------- sequencer ----------------
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: if (start) begin
        ptr_d   = base_addr;
        rem_d   = num_pairs;
        state_d = (num_pairs == '0) ? DONE : ISSUE;
      end
      ISSUE: if (issue) begin
        ptr_d = ptr_q + ADDR_W'(2);
        rem_d = rem_q - ADDR_W'(1);
        if (rem_q == ADDR_W'(1)) state_d = DRAIN;
      end
      // Leave as soon as the final pop is happening so done follows it by one cycle.
      DRAIN: if (in_flight == '0 && fifo_cnt_d == '0) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

  assign busy = (state_q == ISSUE) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  // ---------------- read-latency tag pipeline ----------------
  always_comb begin
    tag_in       = '0;
    tag_in.valid = issue;
    tag_in.last  = issue && (rem_q == ADDR_W'(1));
    tag_in.pad_a = issue && pad_a;
    tag_in.pad_b = issue && pad_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_out = tag_q[RD_LAT-1];

  always_comb begin
    push_data = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (!tag_out.pad_a) push_data[word_idx(b, 1'b0)*DATA_W +: DATA_W] = rd_a[b];
      if (!tag_out.pad_b) push_data[word_idx(b, 1'b1)*DATA_W +: DATA_W] = rd_b[b];
    end
  end

  // ---------------- output FIFO ----------------
  assign push       = tag_out.valid;
  assign pop        = out_valid && out_ready;
  assign fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fifo_cnt_q <= fifo_cnt_d;
      if (push) wr_ptr_q <= bump(wr_ptr_q);
      if (pop)  rd_ptr_q <= bump(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_last_q[wr_ptr_q] <= tag_out.last;
    end
  end

  assign out_valid = (fifo_cnt_q != '0);
  assign out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign out_last  = out_valid && fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_dense_wmem_stream.sv
// Self-checking bench for dense_wmem_stream. A queue of expected beats is
// built from a plain memory image whenever a burst is launched; one compare
// process checks outputs at every negative edge. Honours
// DENSE_WMEM_ZERO_PAD_EN for expected wrap values.
module tb_dense_wmem_stream;

  localparam int NB     = 16;
  localparam int DW     = 32;
  localparam int DEPTH  = 256;
  localparam int AW     = 8;
  localparam int BW     = 4;
  localparam int RD_LAT = 1;
  localparam int OW     = 2 * NB * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] num_pairs = '0;
  logic          busy, done, out_valid, out_last;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
  logic          wr_en = 1'b0;
  logic [BW-1:0] wr_bank = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;

  dense_wmem_stream #(
    .NUM_BANKS(NB), .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_pairs(num_pairs), .busy(busy), .done(done), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  // ---------------- reference model ----------------
  typedef struct {
    logic [OW-1:0] data;
    logic          last;
  } beat_t;

  logic [DW-1:0] mem_m [NB][DEPTH];
  beat_t         exp_q [$];

  function automatic beat_t model_beat(input int base, input int k, input int n);
    beat_t bt;
    int ra, rb;
    logic [DW-1:0] wa, wb;
    ra = base + 2 * k;
    rb = ra + 1;
    bt.data = '0;
    for (int b = 0; b < NB; b++) begin
      wa = mem_m[b][ra % DEPTH];
      wb = mem_m[b][rb % DEPTH];
`ifdef DENSE_WMEM_ZERO_PAD_EN
      if (ra >= DEPTH) wa = '0;
      if (rb >= DEPTH) wb = '0;
`endif
      bt.data[(2*b)*DW +: DW]   = wa;
      bt.data[(2*b+1)*DW +: DW] = wb;
    end
    bt.last = (k == n - 1);
    return bt;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_data(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    int w;
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      w = 0;
      for (int i = 2 * NB - 1; i >= 0; i--)
        if (act[i*DW +: DW] !== exp[i*DW +: DW]) w = i;
      $display("FAIL %s word %0d: got %h expected %h (t=%0t)", name, w,
               act[w*DW +: DW], exp[w*DW +: DW], $time);
    end
  endtask

  // ---------------- out_ready driver ----------------
  int ready_mode = 0;  // 0 high, 1 pattern 1,0,0,1, 2 random, 3 low
  int ready_idx  = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = (ready_idx % 4 == 0) || (ready_idx % 4 == 3);
        ready_idx++;
      end
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------- compare process ----------------
  logic          busy_exp = 1'b0, done_exp = 1'b0, first_pending = 1'b0;
  logic          prev_stall = 1'b0, prev_last = 1'b0;
  logic [OW-1:0] prev_data = '0, first_pop = '0, last_pop = '0;
  int            start_cyc = 0;

  always @(negedge clk) begin
    logic  done_nx, busy_nx;
    beat_t bt;
    if (!rst_n) begin
      exp_q.delete();
      busy_exp      = 1'b0;
      done_exp      = 1'b0;
      first_pending = 1'b0;
      prev_stall    = 1'b0;
      check("rst_out_valid", out_valid, 1'b0);
    end else begin
      check("done", done, done_exp);
      check("busy", busy, busy_exp);
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check_data("stall_data", out_data, prev_data);
        check("stall_last", out_last, prev_last);
      end
      if (out_valid && first_pending) begin
        check("first_latency", 64'(cyc - start_cyc), 64'(1 + RD_LAT + 1));
        first_pending = 1'b0;
        first_pop     = out_data;
      end
      done_nx = 1'b0;
      busy_nx = busy_exp;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL spurious_beat: got a beat with none expected (t=%0t)", $time);
        end else begin
          bt = exp_q.pop_front();
          check_data("beat_data", out_data, bt.data);
          check("beat_last", out_last, bt.last);
          last_pop = out_data;
          if (bt.last) begin
            done_nx = 1'b1;
            busy_nx = 1'b0;
          end
        end
      end
      if (start && !busy_exp && !done_exp) begin
        if (num_pairs == '0) done_nx = 1'b1;
        else begin
          busy_nx       = 1'b1;
          first_pending = 1'b1;
          start_cyc     = cyc;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      done_exp   = done_nx;
      busy_exp   = busy_nx;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_burst(input int base, input int n, input bit accept);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = AW'(base);
    num_pairs = AW'(n);
    if (accept)
      for (int k = 0; k < n; k++) exp_q.push_back(model_beat(base, k, n));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max, output int waited);
    bit found;
    found  = 1'b0;
    waited = 0;
    while (!found && waited < max) begin
      @(negedge clk);
      waited++;
      if (done === 1'b1) found = 1'b1;
    end
    check(name, found, 1'b1);
  endtask

  task automatic write_word(input int b, input int r, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    wr_en   = 1'b1;
    wr_bank = BW'(b);
    wr_addr = AW'(r);
    wr_data = d;
    mem_m[b][r] = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int w;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_last", out_last, 1'b0);
    check_data("rst_data", out_data, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Preload bank b row r with {b, r}.
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < DEPTH; r++) begin
        @(posedge clk);
        #1;
        wr_en   = 1'b1;
        wr_bank = BW'(b);
        wr_addr = AW'(r);
        wr_data = {8'(b), 24'(r)};
        mem_m[b][r] = {8'(b), 24'(r)};
      end
    @(posedge clk);
    #1 wr_en = 1'b0;

    // Basic burst of 4 with out_ready high.
    start_burst(0, 4, 1'b1);
    wait_done("t1_done_seen", 100, w);
    check("t1_done_cycle", 64'(cyc - start_cyc), 64'd7);
    check("t1_first_w0", first_pop[0*DW +: DW], 32'h0000_0000);
    check("t1_first_w7", first_pop[7*DW +: DW], 32'h0300_0001);
    check("t1_last_w6", last_pop[6*DW +: DW], 32'h0300_0006);
    check("t1_last_w31", last_pop[31*DW +: DW], 32'h0F00_0007);

    // Zero pairs: done the cycle right after start.
    start_burst(5, 0, 1'b1);
    wait_done("t2_done_seen", 10, w);
    check("t2_done_delay", 64'(w), 64'd1);

    // Burst of 8 with ready 1,0,0,1 and an ignored start while busy.
    ready_idx  = 0;
    ready_mode = 1;
    start_burst(20, 8, 1'b1);
    repeat (3) @(posedge clk);
    start_burst(100, 3, 1'b0);
    wait_done("t3_done_seen", 200, w);
    ready_mode = 0;

    // Wrap across DEPTH-1.
    start_burst(254, 2, 1'b1);
    wait_done("t4_done_seen", 100, w);
    check("t4_first_w2", first_pop[2*DW +: DW], 32'h0100_00FE);
    check("t4_first_w3", first_pop[3*DW +: DW], 32'h0100_00FF);
    check("t4_last_w0", last_pop[0*DW +: DW], 32'h0000_0000);
`ifdef DENSE_WMEM_ZERO_PAD_EN
    check("t4_last_w3", last_pop[3*DW +: DW], 32'h0000_0000);
`else
    check("t4_last_w3", last_pop[3*DW +: DW], 32'h0100_0001);
`endif

    // Write collides with the read of bank 3 row 6.
    start_burst(6, 1, 1'b1);
    wr_en   = 1'b1;
    wr_bank = BW'(3);
    wr_addr = AW'(6);
    wr_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 wr_en = 1'b0;
    mem_m[3][6] = 32'hDEAD_BEEF;
    wait_done("t5a_done_seen", 100, w);
    check("t5a_old_word", last_pop[6*DW +: DW], 32'h0300_0006);
    start_burst(6, 1, 1'b1);
    wait_done("t5b_done_seen", 100, w);
    check("t5b_new_word", last_pop[6*DW +: DW], 32'hDEAD_BEEF);

    // Reset while draining.
    ready_mode = 3;
    start_burst(40, 2, 1'b1);
    repeat (4) @(posedge clk);
    check("t6_pre_valid", out_valid, 1'b1);
    check("t6_pre_busy", busy, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_done", done, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ready_mode = 0;
    start_burst(10, 3, 1'b1);
    wait_done("t6_after_done_seen", 100, w);

    // Randomised bursts, writes and backpressure.
    ready_mode = 2;
    for (int it = 0; it < 16; it++) begin
      for (int j = 0; j < 3; j++)
        write_word(int'($urandom_range(0, NB - 1)), int'($urandom_range(0, DEPTH - 1)), $urandom);
      start_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 12)), 1'b1);
      wait_done("rand_done_seen", 2000, w);
    end
    ready_mode = 0;

    repeat (3) @(posedge clk);
    check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
